// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: line geometry, AXI burst constants
// and the refill engine state encoding. The icache controller imports this
// package too, so geometry changes stay consistent across the cache.
package icache_pkg;

   localparam int LINE_SIZE    = 64;
   localparam int OFFSET_WIDTH = 6;
   localparam int INDEX_WIDTH  = 6;
   localparam int TAG_WIDTH    = 20;
   localparam int BEATS        = LINE_SIZE * 8 / 64;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_8B    = 3'b011;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      DONE
   } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine. Takes a miss address, issues one
// AXI4 INCR burst covering the whole line, packs the beats into a line
// register and reports completion with a single-cycle pulse. Every output
// comes from a register or from the state, so the cache sees no
// combinational path from the AXI side.
module icache_refill
   import icache_pkg::*;
#(
   parameter int LINE_SIZE  = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [31:0]            req_addr,
   output logic                   arvalid,
   input  logic                   arready,
   output logic [31:0]            araddr,
   output logic [7:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [DATA_WIDTH-1:0]  rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   output logic                   line_valid,
   output logic [LINE_SIZE*8-1:0] line_data,
   output logic                   line_err
);

   localparam int BEATS = LINE_SIZE * 8 / DATA_WIDTH;
   localparam int CNT_W = $clog2(BEATS);

   refill_state_e          state_q, state_d;
   logic [31:0]            addr_q, addr_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic                   err_q, err_d;
   logic [LINE_SIZE*8-1:0] line_q, line_d;

   logic acceptReq;
   logic arFire;
   logic beatFire;
   logic lastBeat;

   // Handshakes are decoded from state, so readiness never depends on inputs
   assign acceptReq = (state_q == IDLE) && req_valid;
   assign arFire    = (state_q == ADDR) && arready;
   assign beatFire  = (state_q == DATA) && rvalid;
   assign lastBeat  = (beat_cnt_q == CNT_W'(BEATS - 1));

   // State register; reset drops any partial burst immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: the beat count, not rlast, decides when the burst ends
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (acceptReq) state_d = ADDR;
         ADDR: if (arFire) state_d = DATA;
         DATA: if (beatFire && lastBeat) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state or taken straight from registers
   always_comb begin
      req_ready  = (state_q == IDLE);
      arvalid    = (state_q == ADDR);
      rready     = (state_q == DATA);
      line_valid = (state_q == DONE);
      line_err   = (state_q == DONE) && err_q;
      araddr     = addr_q;
      line_data  = line_q;
      arlen      = 8'(BEATS - 1);
      arsize     = SIZE_8B;
      arburst    = BURST_INCR;
   end

   // Datapath next values: latch the line-aligned address, pack beats into
   // their slots and keep a sticky error for bad responses or a misplaced rlast
   always_comb begin
      addr_d     = addr_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      line_d     = line_q;
      if (acceptReq) begin
         addr_d     = req_addr & ~32'(LINE_SIZE - 1);
         beat_cnt_d = '0;
         err_d      = 1'b0;
      end
      if (beatFire) begin
         line_d[beat_cnt_q*DATA_WIDTH +: DATA_WIDTH] = rdata;
         beat_cnt_d = beat_cnt_q + 1'b1;
         if ((rresp != 2'b00) || (rlast != lastBeat)) begin
            err_d = 1'b1;
         end
      end
   end

   // Datapath registers; the line is kept after completion until overwritten
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         line_q     <= '0;
      end else begin
         addr_q     <= addr_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
         line_q     <= line_d;
      end
   end

endmodule

// File: tb/tb_icache_refill.sv
// Testbench for icache_refill: acts as the icache requester and as an AXI
// read slave, with a line-level reference model that predicts the returned
// line and error flag from the beats it hands out.
module tb_icache_refill;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         rvalid;
   logic         rready;
   logic [63:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         line_valid;
   logic [511:0] line_data;
   logic         line_err;

   int checks = 0;
   int errors = 0;

   icache_refill dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .arvalid    (arvalid),
      .arready    (arready),
      .araddr     (araddr),
      .arlen      (arlen),
      .arsize     (arsize),
      .arburst    (arburst),
      .rvalid     (rvalid),
      .rready     (rready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rlast      (rlast),
      .line_valid (line_valid),
      .line_data  (line_data),
      .line_err   (line_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the engine locks up somewhere unexpected
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs that must hold their reset values
   task automatic checkResetValues(input string phase);
      checkOutput({phase, "ReqReady"},  req_ready,  1);
      checkOutput({phase, "Arvalid"},   arvalid,    0);
      checkOutput({phase, "Rready"},    rready,     0);
      checkOutput({phase, "LineValid"}, line_valid, 0);
      checkOutput({phase, "LineErr"},   line_err,   0);
      checkOutput({phase, "LineData"},  line_data,  0);
      checkOutput({phase, "Araddr"},    araddr,     0);
   endtask

   // One complete refill. gapMode: 0 rvalid always high, 1 alternating
   // starting with a gap, 2 random gaps. errBeat gets rresp=SLVERR, rlast is
   // driven only on beat lastBeat, resetBeat pulses rst_n while that beat is
   // on the bus (negative values disable each feature).
   task automatic applyStimulus(input logic [31:0] addr, input int arStall, input int gapMode,
                                input int errBeat, input int lastBeat, input bit seqBeats,
                                input int resetBeat);
      logic [63:0]  beats [8];
      logic [511:0] expLine;
      logic [31:0]  expAddr;
      logic         expErr;
      int           k;
      int           budget;
      bit           rv;

      for (int i = 0; i < 8; i++) begin
         beats[i] = seqBeats ? 64'(i) : {$urandom, $urandom};
      end
      expAddr = addr & 32'hFFFF_FFC0;
      expLine = '0;
      expErr  = 1'b0;

      checkOutput("idleReqReady", req_ready, 1);
      req_valid = 1'b1;
      req_addr  = addr;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;

      for (int s = 0; s < arStall; s++) begin
         arready = 1'b0;
         rvalid  = 1'b1;
         rdata   = {$urandom, $urandom};
         rresp   = 2'b00;
         rlast   = 1'b1;
         checkOutput("stallArvalid", arvalid, 1);
         checkOutput("stallAraddr",  araddr,  expAddr);
         checkOutput("stallRready",  rready,  0);
         @(posedge clk); #1;
      end

      arready = 1'b1;
      rvalid  = 1'b0;
      checkOutput("arvalid",    arvalid,   1);
      checkOutput("araddr",     araddr,    expAddr);
      checkOutput("arlen",      arlen,     7);
      checkOutput("arsize",     arsize,    3);
      checkOutput("arburst",    arburst,   1);
      checkOutput("addrReqRdy", req_ready, 0);
      @(posedge clk); #1;

      k = 0;
      budget = 0;
      while (k < 8 && budget < 200) begin
         case (gapMode)
            0:       rv = 1'b1;
            1:       rv = (budget % 2 == 1);
            default: rv = ($urandom_range(0, 2) != 0);
         endcase
         rvalid = rv;
         rdata  = rv ? beats[k] : {$urandom, $urandom};
         rresp  = (k == errBeat) ? 2'b10 : 2'b00;
         rlast  = (k == lastBeat);
         checkOutput("dataRready",  rready,     1);
         checkOutput("noEarlyLine", line_valid, 0);
         if (rv && k == resetBeat) begin
            #2 rst_n = 1'b0;
            #1 checkResetValues("midReset");
            #2 rst_n = 1'b1;
            rvalid = 1'b0;
            @(posedge clk); #1;
            checkResetValues("postMidReset");
            return;
         end
         if (rv) begin
            if (rresp != 2'b00 || rlast != (k == 7)) expErr = 1'b1;
            expLine[k*64 +: 64] = beats[k];
            k++;
         end
         @(posedge clk); #1;
         budget++;
      end
      if (k < 8) checkOutput("dataTimeout", k, 8);
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;

      checkOutput("lineValid",   line_valid, 1);
      checkOutput("lineErr",     line_err,   expErr);
      checkOutput("lineData",    line_data,  expLine);
      checkOutput("doneReqRdy",  req_ready,  0);
      checkOutput("doneRready",  rready,     0);
      @(posedge clk); #1;
      checkOutput("pulseEnded",  line_valid, 0);
      checkOutput("errCleared",  line_err,   0);
      checkOutput("idleAgain",   req_ready,  1);
      checkOutput("lineHeld",    line_data,  expLine);
   endtask

   initial begin
      int eb;
      int lb;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rdata     = '0;
      rresp     = 2'b00;
      rlast     = 1'b0;

      #2 checkResetValues("inReset");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      checkResetValues("afterReset");

      // Sequential beats with no stalls: minimum latency, slot k holds k
      applyStimulus(32'h8000_1234, 0, 0, -1, 7, 1'b1, -1);
      // Address channel stalled five cycles
      applyStimulus($urandom, 5, 0, -1, 7, 1'b0, -1);
      // rvalid every other cycle
      applyStimulus($urandom, 0, 1, -1, 7, 1'b0, -1);
      // Error response on beat 3
      applyStimulus($urandom, 0, 0, 3, 7, 1'b0, -1);
      // Early rlast on beat 5 (and therefore missing on beat 7)
      applyStimulus($urandom, 0, 0, -1, 5, 1'b0, -1);
      // rlast never asserted
      applyStimulus($urandom, 0, 0, -1, -1, 1'b0, -1);
      // Reset during beat 4, then a clean refill
      applyStimulus($urandom, 0, 0, -1, 7, 1'b0, 4);
      applyStimulus(32'h8000_0040, 0, 0, -1, 7, 1'b0, -1);

      // Randomized refills with random stalls, gaps and protocol errors
      for (int n = 0; n < 12; n++) begin
         eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 7;
         applyStimulus($urandom, int'($urandom_range(0, 3)), 2, eb, lb, 1'b0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
